// File: rtl/tank_motion_if.sv
// Bundles the decoder-side request and the renderer/collision-side outputs of tank_motion.
// The master drives the request; the slave (tank_motion) drives position and status.
interface tank_motion_if;
  logic [2:0] direct;
  logic       moving;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [1:0] heading;
  logic       turning;
  logic       step_pulse;
  logic       at_wall;

  modport master (
    output direct, moving,
    input  pos_x, pos_y, heading, turning, step_pulse, at_wall
  );

  modport slave (
    input  direct, moving,
    output pos_x, pos_y, heading, turning, step_pulse, at_wall
  );
endinterface

// File: rtl/tank_motion.sv
// Player-tank position integrator: prescaled stepping, turn penalty, edge clamping.
// Define TANK_WRAP_EN to wrap around screen edges instead of clamping (at_wall then tied to 0).
module tank_motion #(
  parameter int unsigned STEP_DIV = 1_000_000,
  parameter int unsigned STEP     = 2,
  parameter int unsigned X_MAX    = 623,
  parameter int unsigned Y_MAX    = 463,
  parameter int unsigned X_INIT   = 304,
  parameter int unsigned Y_INIT   = 224
) (
  input  logic            clk_100mhz,
  input  logic            rst,
  tank_motion_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, TURN, MOVE} state_t;

  localparam logic [31:0] TICK_AT = 32'(STEP_DIV - 1);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [9:0]  X_LIM   = 10'(X_MAX);
  localparam logic [9:0]  Y_LIM   = 10'(Y_MAX);

  state_t      state_p0, state_p1;
  logic [31:0] cnt_p0, cnt_p1;
  logic [1:0]  heading_p0, heading_p1;
  logic [9:0]  pos_x_p0, pos_x_p1;
  logic [9:0]  pos_y_p0, pos_y_p1;
  logic        vld_p0, vld_p1;
  logic        at_wall_p1;
  logic        req_ok, same_dir, tick;

  // One axis step in 11 bits so x+STEP cannot overflow before the edge test.
  function automatic logic [9:0] step_axis(input logic [9:0] v, input logic [9:0] lim,
                                           input logic inc);
    logic [10:0] w;
    logic [10:0] l;
    w = {1'b0, v};
    l = {1'b0, lim};
    if (inc) begin
      w = w + STEP_W;
`ifdef TANK_WRAP_EN
      if (w > l) w = w - (l + 11'd1);
`else
      if (w > l) w = l;
`endif
    end else if (w < STEP_W) begin
`ifdef TANK_WRAP_EN
      w = w + l + 11'd1 - STEP_W;
`else
      w = '0;
`endif
    end else begin
      w = w - STEP_W;
    end
    return w[9:0];
  endfunction

`ifndef TANK_WRAP_EN
  function automatic logic wall(input logic [1:0] h, input logic [9:0] x, input logic [9:0] y);
    case (h)
      2'd0:    return x == 10'd0;
      2'd1:    return x == X_LIM;
      2'd2:    return y == 10'd0;
      default: return y == Y_LIM;
    endcase
  endfunction
`endif

  assign req_ok   = bus.moving & ~bus.direct[2];
  assign same_dir = (bus.direct[1:0] == heading_p1);
  assign tick     = (cnt_p1 == TICK_AT);

  always_comb begin
    state_p0   = state_p1;
    cnt_p0     = cnt_p1;
    heading_p0 = heading_p1;
    pos_x_p0   = pos_x_p1;
    pos_y_p0   = pos_y_p1;
    vld_p0     = 1'b0;
    case (state_p1)
      IDLE: begin
        cnt_p0 = '0;
        if (req_ok) begin
          if (same_dir) begin
            state_p0 = MOVE;
          end else begin
            heading_p0 = bus.direct[1:0];
            state_p0   = TURN;
          end
        end
      end
      TURN: begin
        cnt_p0 = tick ? '0 : cnt_p1 + 32'd1;
        if (!req_ok) begin
          state_p0 = IDLE;
          cnt_p0   = '0;
        end else if (!same_dir) begin
          heading_p0 = bus.direct[1:0];
          cnt_p0     = '0;
        end else if (tick) begin
          state_p0 = MOVE;
        end
      end
      MOVE: begin
        cnt_p0 = tick ? '0 : cnt_p1 + 32'd1;
        // Release and re-aim both take priority over a coincident tick.
        if (!req_ok) begin
          state_p0 = IDLE;
          cnt_p0   = '0;
        end else if (!same_dir) begin
          heading_p0 = bus.direct[1:0];
          state_p0   = TURN;
          cnt_p0     = '0;
        end else if (tick) begin
          vld_p0 = 1'b1;
          case (heading_p1)
            2'd0:    pos_x_p0 = step_axis(pos_x_p1, X_LIM, 1'b0);
            2'd1:    pos_x_p0 = step_axis(pos_x_p1, X_LIM, 1'b1);
            2'd2:    pos_y_p0 = step_axis(pos_y_p1, Y_LIM, 1'b0);
            default: pos_y_p0 = step_axis(pos_y_p1, Y_LIM, 1'b1);
          endcase
        end
      end
      default: begin
        state_p0 = IDLE;
        cnt_p0   = '0;
      end
    endcase
  end

  // Stage boundary: registered state, prescaler, position and status.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_p1   <= IDLE;
      cnt_p1     <= '0;
      heading_p1 <= 2'd2;
      pos_x_p1   <= 10'(X_INIT);
      pos_y_p1   <= 10'(Y_INIT);
      vld_p1     <= 1'b0;
      at_wall_p1 <= 1'b0;
    end else begin
      state_p1   <= state_p0;
      cnt_p1     <= cnt_p0;
      heading_p1 <= heading_p0;
      pos_x_p1   <= pos_x_p0;
      pos_y_p1   <= pos_y_p0;
      vld_p1     <= vld_p0;
`ifdef TANK_WRAP_EN
      at_wall_p1 <= 1'b0;
`else
      at_wall_p1 <= wall(heading_p1, pos_x_p1, pos_y_p1);
`endif
    end
  end

  assign bus.pos_x      = pos_x_p1;
  assign bus.pos_y      = pos_y_p1;
  assign bus.heading    = heading_p1;
  assign bus.turning    = (state_p1 == TURN);
  assign bus.step_pulse = vld_p1;
  assign bus.at_wall    = at_wall_p1;

endmodule

// File: doc/tank_motion.md
# tank_motion

Position integrator downstream of the button-to-direction decoder. Consumes the registered `direct`/`moving` pair and advances the player tank's top-left pixel coordinate at a fixed, prescaled step rate. A turn costs one step period before motion resumes. Outputs feed the VGA sprite renderer and the collision checker.

## Interface

Parameters:
- `STEP_DIV`, 1_000_000: clock cycles per motion step.
- `STEP`, 2: pixels per step.
- `X_MAX`, 623: largest legal `pos_x` (640 − 16-px sprite − 1).
- `Y_MAX`, 463: largest legal `pos_y`.
- `X_INIT`, 304: `pos_x` after reset.
- `Y_INIT`, 224: `pos_y` after reset.

Ports:
- `clk_100mhz`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `direct`  in  3  requested direction: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN; values 4–7 are invalid.
- `moving`  in  1  a direction button is held.
- `pos_x`  out  10  tank x, registered.
- `pos_y`  out  10  tank y, registered.
- `heading`  out  2  current facing, same encoding as `direct[1:0]`.
- `turning`  out  1  high while in TURN.
- `step_pulse`  out  1  one-cycle pulse in the cycle after each position update.
- `at_wall`  out  1  tank is flush with the edge it faces.

## Operation

- A request is valid when `moving`=1 and `direct[2]`=0. Any other input is treated as release.
- Prescaler `cnt` is 32 bits. A tick occurs when `cnt`==STEP_DIV−1; on a tick `cnt` returns to 0.
- States:
  - **IDLE**
    - `cnt` held at 0.
    - Valid request with `direct[1:0]`==`heading`: go to MOVE, `cnt`←0.
    - Valid request with a different direction: `heading`←`direct[1:0]`, go to TURN, `cnt`←0.
  - **TURN**
    - `cnt` counts.
    - Release: go to IDLE.
    - Valid request naming a different direction: `heading` updates and `cnt`←0, staying in TURN.
    - Tick: go to MOVE.
    - No position change in this state.
  - **MOVE**
    - `cnt` counts.
    - Release: go to IDLE, `cnt`←0. A tick in the same cycle as release is ignored.
    - Valid request with a different direction: go to TURN with the new `heading`, `cnt`←0. A tick in the same cycle is ignored.
    - Otherwise, on a tick: update position by `heading` and set `step_pulse`←1 for the next cycle.
- Position arithmetic:
  - Screen coordinates: UP decrements y, LEFT decrements x.
  - Unsigned, computed in 11 bits internally.
  - Clamp mode:
    - LEFT: x<STEP gives x←0.
    - RIGHT: x+STEP>X_MAX gives x←X_MAX.
    - UP/DOWN apply the same rule to y with Y_MAX.
- `at_wall` is registered every cycle:
  - 1 iff (`heading`=LEFT and x=0), (RIGHT and x=X_MAX), (UP and y=0), or (DOWN and y=Y_MAX).
  - It is evaluated on the post-update values, so it lags a position or heading change by one cycle.
- `turning` = (state==TURN), registered with the state.

## Timing

- Reset values:
  - `pos_x`=X_INIT, `pos_y`=Y_INIT
  - `heading`=UP (2)
  - state IDLE, `cnt`=0
  - `step_pulse`=0, `turning`=0, `at_wall`=0
- `rst` overrides every other input. Asserting it mid-step discards the partial `cnt` with no position update.
- From the edge where IDLE samples a valid same-direction request, the first position update lands STEP_DIV edges later. Later updates follow every STEP_DIV cycles.
- A direction change adds one full step period (STEP_DIV cycles in TURN) before the first STEP_DIV-cycle MOVE period.
- `step_pulse` is high exactly one cycle, the cycle in which the new `pos_x`/`pos_y` is first visible.
- STEP_DIV must be ≥2.

## Configuration

- `TANK_WRAP_EN` defined: edges wrap instead of clamping, and `at_wall` is tied to 0.
  - LEFT with x<STEP gives x←x−STEP+X_MAX+1.
  - RIGHT with x+STEP>X_MAX gives x←x+STEP−(X_MAX+1).
  - y wraps the same way using Y_MAX.
- Undefined (default): clamp behaviour and `at_wall` exactly as in Operation.

## Test plan

Bench parameters: STEP_DIV=4, STEP=2, X_MAX=15, Y_MAX=15, X_INIT=8, Y_INIT=8.

- Reset, then hold `direct`=2, `moving`=1 → state MOVE at once. `pos_y` goes 6, 4, 2, 0 on every 4th edge, with `step_pulse` alongside each update. `pos_y` then holds at 0 and `at_wall`=1.
- From reset, apply `direct`=0 with `moving`=1 → `turning`=1 for 4 cycles, `heading`=0, then `pos_x`=6 four cycles after TURN exits.
- In MOVE, drop `moving` on the tick cycle → no update, state IDLE, `cnt`=0. Reasserting `moving` gives the next update 4 cycles later.
- Apply `direct`=5 with `moving`=1 → stays IDLE, outputs unchanged.
- Assert `rst` for one cycle with `cnt`=2 in MOVE → all outputs back to reset values on the next edge.
- With `TANK_WRAP_EN`: at x=0 moving LEFT → next step gives x=14. `at_wall` stays 0 throughout.
